// File: rtl/req_resp_pkg.sv
// Shared constants for the req/resp responder slice.
// Holds the default trigger/response timing, the statistics counter width
// and the helper that sizes the pending-response delay line.
package req_resp_pkg;

   localparam int unsigned REQ_LEN_DEF  = 2;
   localparam int unsigned DELAY_DEF    = 4;
   localparam int unsigned RESP_LEN_DEF = 2;
   localparam int unsigned CNT_W        = 16;

   // Delay-line length: the last tap holds a trigger's final resp sample.
   function automatic int unsigned line_len(input int unsigned delay,
                                            input int unsigned resp_len);
      return delay + resp_len - 1;
   endfunction

endpackage

// File: rtl/req_resp_delay_line.sv
// Shift register of pending triggers with a registered OR over its tail taps.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   in_bit      trigger pulse entering bit 0
//   tap_or      registered OR of taps TAP_LO..LEN-1 (the response)
//   any_set     registered "any bit set or response high"
//   tail        last bit of the line (only with REQ_RESP_STATS_EN)
module req_resp_delay_line #(
   parameter int unsigned LEN    = 5,
   parameter int unsigned TAP_LO = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic in_bit,
   output logic tap_or,
   output logic any_set
`ifdef REQ_RESP_STATS_EN
   ,
   output logic tail
`endif
);

   logic [LEN-1:0] line_q, line_d;
   logic           tap_or_q, tap_or_d;
   logic           any_q, any_d;

   // Next line contents and the output taps computed from them, so the
   // response flop lines up with the shifted line.
   always_comb begin
      line_d    = '0;
      tap_or_d  = 1'b0;
      line_d[0] = in_bit;
      for (int unsigned i = 1; i < LEN; i++) begin
         line_d[i] = line_q[i-1];
      end
      for (int unsigned i = TAP_LO; i < LEN; i++) begin
         tap_or_d = tap_or_d | line_d[i];
      end
      any_d = (|line_d) | tap_or_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         line_q   <= '0;
         tap_or_q <= 1'b0;
         any_q    <= 1'b0;
      end else begin
         line_q   <= line_d;
         tap_or_q <= tap_or_d;
         any_q    <= any_d;
      end
   end

   assign tap_or  = tap_or_q;
   assign any_set = any_q;
`ifdef REQ_RESP_STATS_EN
   assign tail    = line_q[LEN-1];
`endif

endmodule

// File: rtl/req_resp_responder.sv
// Responder: after REQ_LEN consecutive req-high samples (with en high on the
// last one) it drives resp high for RESP_LEN samples starting DELAY posedges
// later. Overlapping triggers are all honoured.
// Optional feature macro: REQ_RESP_STATS_EN adds trig_cnt / resp_cnt.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   en          trigger enable (does not cancel pending responses)
//   clr         synchronous clear of ovl_err and the counters
//   req         request input
//   resp        registered response
//   busy        registered: a response is pending or active
//   ovl_err     sticky: a trigger arrived while busy
//   trig_cnt    saturating count of accepted triggers (stats build only)
//   resp_cnt    saturating count of completed resp windows (stats build only)
module req_resp_responder
   import req_resp_pkg::*;
#(
   parameter int unsigned REQ_LEN  = REQ_LEN_DEF,
   parameter int unsigned DELAY    = DELAY_DEF,
   parameter int unsigned RESP_LEN = RESP_LEN_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   input  logic req,
   output logic resp,
   output logic busy,
   output logic ovl_err
`ifdef REQ_RESP_STATS_EN
   ,
   output logic [CNT_W-1:0] trig_cnt,
   output logic [CNT_W-1:0] resp_cnt
`endif
);

   localparam int unsigned RUN_W    = $clog2(REQ_LEN + 1);
   localparam int unsigned LINE_LEN = line_len(DELAY, RESP_LEN);

   logic [RUN_W-1:0] run_q, run_d;
   logic             ovl_q, ovl_d;
   logic             trig_c;
   logic             resp_w, busy_w;
`ifdef REQ_RESP_STATS_EN
   logic             tail_w;
   logic [CNT_W-1:0] trig_cnt_q, trig_cnt_d;
   logic [CNT_W-1:0] resp_cnt_q, resp_cnt_d;
`endif

   // Run counter holds the number of consecutive req-high samples before
   // this edge, so a trigger needs REQ_LEN-1 of them plus req now.
   always_comb begin
      trig_c = req & en & (run_q >= RUN_W'(REQ_LEN - 1));
      run_d  = run_q;
      if (!req) begin
         run_d = '0;
      end else if (run_q != RUN_W'(REQ_LEN)) begin
         run_d = run_q + RUN_W'(1);
      end
      // A trigger in the same cycle as clr still sets the flag.
      ovl_d = (ovl_q & ~clr) | (trig_c & busy_w);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_q <= '0;
         ovl_q <= 1'b0;
      end else begin
         run_q <= run_d;
         ovl_q <= ovl_d;
      end
   end

   req_resp_delay_line #(
      .LEN    (LINE_LEN),
      .TAP_LO (DELAY - 1)
   ) u_line (
      .clk     (clk),
      .rst_n   (rst_n),
      .in_bit  (trig_c),
      .tap_or  (resp_w),
      .any_set (busy_w)
`ifdef REQ_RESP_STATS_EN
      ,
      .tail    (tail_w)
`endif
   );

`ifdef REQ_RESP_STATS_EN
   // Saturating statistics; a set tail bit marks a trigger's final resp sample.
   always_comb begin
      trig_cnt_d = trig_cnt_q;
      resp_cnt_d = resp_cnt_q;
      if (clr) begin
         trig_cnt_d = '0;
         resp_cnt_d = '0;
      end else begin
         if (trig_c && (trig_cnt_q != {CNT_W{1'b1}})) begin
            trig_cnt_d = trig_cnt_q + CNT_W'(1);
         end
         if (tail_w && (resp_cnt_q != {CNT_W{1'b1}})) begin
            resp_cnt_d = resp_cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         trig_cnt_q <= '0;
         resp_cnt_q <= '0;
      end else begin
         trig_cnt_q <= trig_cnt_d;
         resp_cnt_q <= resp_cnt_d;
      end
   end

   assign trig_cnt = trig_cnt_q;
   assign resp_cnt = resp_cnt_q;
`endif

   assign resp    = resp_w;
   assign busy    = busy_w;
   assign ovl_err = ovl_q;

endmodule

// File: tb/tb_req_resp_responder.sv
// Directed bench for req_resp_responder (default parameters).
// Column i of each vector is the input applied before posedge i and the
// expected resp/busy/ovl_err value right after posedge i.
module tb_req_resp_responder;

   logic clk = 1'b0;
   logic rst_n;
   logic en;
   logic clr;
   logic req;
   logic resp;
   logic busy;
   logic ovl_err;
`ifdef REQ_RESP_STATS_EN
   logic [15:0] trig_cnt;
   logic [15:0] resp_cnt;
`endif

   int errors = 0;
   int checks = 0;

   typedef struct {
      string name;
      int    col;
      logic  resp;
      logic  busy;
      logic  ovl;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;

   always #5 clk = ~clk;

   req_resp_responder dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .clr     (clr),
      .req     (req),
      .resp    (resp),
      .busy    (busy),
      .ovl_err (ovl_err)
`ifdef REQ_RESP_STATS_EN
      ,
      .trig_cnt (trig_cnt),
      .resp_cnt (resp_cnt)
`endif
   );

   function automatic logic bit_at(input string s, input int i, input logic dflt);
      byte c;
      if (s.len() == 0) return dflt;
      c = s[i];
      return (c == 8'h31);
   endfunction

   // Drive one vector column per cycle and queue the expected outputs.
   task automatic run_vec(input string name, input string req_s, input string en_s,
                          input string rst_s, input string clr_s, input string resp_s,
                          input string busy_s, input string ovl_s);
      exp_t e;
      for (int i = 0; i < req_s.len(); i++) begin
         @(negedge clk);
         req   = bit_at(req_s, i, 1'b0);
         en    = bit_at(en_s, i, 1'b1);
         rst_n = bit_at(rst_s, i, 1'b1);
         clr   = bit_at(clr_s, i, 1'b0);
         e.name = name;
         e.col  = i;
         e.resp = bit_at(resp_s, i, 1'b0);
         e.busy = bit_at(busy_s, i, 1'b0);
         e.ovl  = bit_at(ovl_s, i, 1'b0);
         exp_q.push_back(e);
      end
   endtask

   // Monitor: compare the DUT outputs after each edge against the queue head.
   always @(posedge clk) begin
      #2;
      if (exp_q.size() != 0) begin
         mon_e = exp_q.pop_front();
         checks++;
         if ({resp, busy, ovl_err} !== {mon_e.resp, mon_e.busy, mon_e.ovl}) begin
            errors++;
            $display("FAIL %s[%0d] resp/busy/ovl got %b%b%b want %b%b%b", mon_e.name,
                     mon_e.col, resp, busy, ovl_err, mon_e.resp, mon_e.busy, mon_e.ovl);
         end
      end
   end

`ifdef REQ_RESP_STATS_EN
   property p_resp;
      @(posedge clk) disable iff (!rst_n) req ##1 (req && en) |-> ##4 resp [*2];
   endproperty
   a_resp: assert property (p_resp)
   else begin
      errors++;
      checks++;
      $display("FAIL req_resp_property at %0t", $time);
   end
`endif

   task automatic drain();
      for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge clk);
      #3;
      if (exp_q.size() != 0) begin
         errors++;
         checks++;
         $display("FAIL drain queue got %0d left want 0", exp_q.size());
      end
   endtask

   initial begin
      rst_n = 1'b0;
      en    = 1'b1;
      clr   = 1'b0;
      req   = 1'b0;

      // Held in reset with req high: everything stays zero.
      run_vec("reset", "1111", "", "0000", "", "0000", "0000", "0000");
      run_vec("basic", "0110000000", "", "", "",
              "0000011000", "0011111000", "0000000000");
      run_vec("no_trig", "0100101000", "", "", "",
              "0000000000", "0000000000", "0000000000");
      run_vec("overlap", "0111000000", "", "", "0000000001",
              "0000011100", "0011111100", "0001111110");
      run_vec("mid_reset", "01100110011000000", "", "11110011111111111", "",
              "00000000000001100", "00110000001111100", "00000000000000000");
      run_vec("en_low", "0110000", "1001111", "", "",
              "0000000", "0000000", "0000000");
      run_vec("en_drop", "0110000000", "1110000000", "", "",
              "0000011000", "0011111000", "0000000000");
      run_vec("long_run", "0111111000000", "", "", "0000100010000",
              "0000011111100", "0011111111100", "0001111100000");

`ifdef REQ_RESP_STATS_EN
      run_vec("stat_clr", "0", "", "", "1", "0", "0", "0");
      for (int n = 0; n < 5; n++) begin
         run_vec("stat_burst", "01100000", "", "", "",
                 "00000110", "00111110", "00000000");
      end
      drain();
      checks++;
      if (trig_cnt !== 16'd5) begin
         errors++;
         $display("FAIL trig_cnt got %0d want 5", trig_cnt);
      end
      checks++;
      if (resp_cnt !== 16'd5) begin
         errors++;
         $display("FAIL resp_cnt got %0d want 5", resp_cnt);
      end
`endif

      drain();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
